// File: rtl/rom_load_arbiter.sv
// rom_load_arbiter: shares the ROM/RAM port between the Z80 bus and the HPS ioctl ROM download.
// Optional ROM_LOAD_CHECKSUM_EN adds a mod-256 sum of the bytes written during a load.
module rom_load_arbiter #(
  parameter int         ADDR_W      = 15,
  parameter logic [7:0] ROM_INDEX   = 8'd1,
  parameter int         HOLD_CYCLES = 1024
) (
  input  logic              clk_sys,
  input  logic              reset_n,
  input  logic              ioctl_download,
  input  logic [7:0]        ioctl_index,
  input  logic              ioctl_wr,
  input  logic [24:0]       ioctl_addr,
  input  logic [7:0]        ioctl_dout,
  output logic              ioctl_wait,
  input  logic              cpu_req,
  input  logic              cpu_we,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [7:0]        cpu_wdata,
  output logic [7:0]        cpu_rdata,
  output logic              cpu_ack,
  output logic              cpu_reset_hold,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [7:0]        mem_wdata,
  output logic              mem_we,
  input  logic [7:0]        mem_rdata,
  output logic              load_done,
  output logic              load_overflow,
  output logic [7:0]        load_checksum
);
  localparam int CW = HOLD_CYCLES > 1 ? $clog2(HOLD_CYCLES) : 1;
  typedef enum logic [1:0] {RUN, DRAIN, LOAD, HOLD} state_t;
  state_t            state_q, state_d;
  logic [CW-1:0]     cnt_q, cnt_d;
  logic              cpu_ack_q, cpu_ack_d, load_done_q, load_done_d;
  logic              ovf_q, ovf_d, buf_valid_q, buf_valid_d, loaded_q, loaded_d;
  logic [ADDR_W-1:0] buf_addr_q, buf_addr_d, mem_addr_q, mem_addr_d;
  logic [7:0]        buf_data_q, buf_data_d, mem_wdata_q, mem_wdata_d;
  logic              trigger, start, accept, capture, in_win, writing, release_c;
  always_comb begin
    trigger     = ioctl_download && ioctl_index == ROM_INDEX;
    accept      = state_q == RUN && cpu_req && !cpu_ack_q;
    start       = trigger && (state_q == RUN || state_q == HOLD);
    capture     = ioctl_wr && (trigger || state_q == DRAIN || state_q == LOAD);
    in_win      = ioctl_addr[24:ADDR_W] == '0;
    writing     = buf_valid_q && (state_q == LOAD || state_q == HOLD);
    release_c   = state_q == HOLD && !trigger && cnt_q == '0;
    state_d     = state_q;
    case (state_q)
      RUN:     state_d = trigger ? (accept ? DRAIN : LOAD) : RUN;
      DRAIN:   state_d = LOAD;
      LOAD:    state_d = ioctl_download ? LOAD : HOLD;
      default: state_d = trigger ? LOAD : (cnt_q == '0 ? RUN : HOLD);
    endcase
    cnt_d       = state_q == LOAD && !ioctl_download ? CW'(HOLD_CYCLES - 1)
                : state_q == HOLD && cnt_q != '0 ? cnt_q - CW'(1) : cnt_q;
    cpu_ack_d   = accept;
    buf_valid_d = capture && in_win ? 1'b1 : (writing ? 1'b0 : buf_valid_q);
    buf_addr_d  = capture ? ioctl_addr[ADDR_W-1:0] : buf_addr_q;
    buf_data_d  = capture ? ioctl_dout : buf_data_q;
    ovf_d       = (ovf_q && !start) || (capture && !in_win);
    loaded_d    = state_q == LOAD || (loaded_q && !release_c);
    load_done_d = release_c && loaded_q;
    mem_we      = accept ? cpu_we : writing;
    mem_addr_d  = accept ? cpu_addr : (writing ? buf_addr_q : mem_addr_q);
    mem_wdata_d = accept ? cpu_wdata : (writing ? buf_data_q : mem_wdata_q);
  end
  always_ff @(posedge clk_sys) begin
    if (!reset_n) begin
      state_q     <= HOLD;
      cnt_q       <= CW'(HOLD_CYCLES - 1);
      cpu_ack_q   <= 1'b0;
      load_done_q <= 1'b0;
      ovf_q       <= 1'b0;
      buf_valid_q <= 1'b0;
      loaded_q    <= 1'b0;
      buf_addr_q  <= '0;
      buf_data_q  <= '0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      cpu_ack_q   <= cpu_ack_d;
      load_done_q <= load_done_d;
      ovf_q       <= ovf_d;
      buf_valid_q <= buf_valid_d;
      loaded_q    <= loaded_d;
      buf_addr_q  <= buf_addr_d;
      buf_data_q  <= buf_data_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
    end
  end
  assign ioctl_wait     = state_q == DRAIN;
  assign cpu_reset_hold = state_q != RUN;
  assign cpu_ack        = cpu_ack_q;
  assign cpu_rdata      = cpu_ack_q ? mem_rdata : '0;
  assign load_done      = load_done_q;
  assign load_overflow  = ovf_q;
  assign mem_addr       = mem_addr_d;
  assign mem_wdata      = mem_wdata_d;
`ifdef ROM_LOAD_CHECKSUM_EN
  logic [7:0] sum_q, sum_d;
  always_comb sum_d = start ? 8'h00 : (writing ? sum_q + buf_data_q : sum_q);
  always_ff @(posedge clk_sys) begin
    if (!reset_n) sum_q <= 8'h00;
    else sum_q <= sum_d;
  end
  assign load_checksum = sum_q;
`else
  assign load_checksum = 8'h00;
`endif
endmodule

// File: tb/tb_rom_load_arbiter.sv
// tb_rom_load_arbiter: scoreboard bench; expected memory writes, CPU acks and load_done pulses are queued with their cycle numbers.
module tb_rom_load_arbiter;
  localparam int AW = 15;
  localparam int H  = 16;
`ifdef ROM_LOAD_CHECKSUM_EN
  localparam bit CS = 1'b1;
`else
  localparam bit CS = 1'b0;
`endif
  logic          clk_sys = 1'b0;
  logic          reset_n, ioctl_download, ioctl_wr, ioctl_wait;
  logic [7:0]    ioctl_index, ioctl_dout;
  logic [24:0]   ioctl_addr;
  logic          cpu_req, cpu_we, cpu_ack, cpu_reset_hold, mem_we, load_done, load_overflow;
  logic [AW-1:0] cpu_addr, mem_addr;
  logic [7:0]    cpu_wdata, cpu_rdata, mem_wdata, mem_rdata, load_checksum;
  rom_load_arbiter #(.ADDR_W(AW), .ROM_INDEX(8'd1), .HOLD_CYCLES(H)) dut (
    .clk_sys(clk_sys), .reset_n(reset_n), .ioctl_download(ioctl_download),
    .ioctl_index(ioctl_index), .ioctl_wr(ioctl_wr), .ioctl_addr(ioctl_addr),
    .ioctl_dout(ioctl_dout), .ioctl_wait(ioctl_wait), .cpu_req(cpu_req),
    .cpu_we(cpu_we), .cpu_addr(cpu_addr), .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata), .cpu_ack(cpu_ack), .cpu_reset_hold(cpu_reset_hold),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_we(mem_we),
    .mem_rdata(mem_rdata), .load_done(load_done), .load_overflow(load_overflow),
    .load_checksum(load_checksum)
  );
  always #5 clk_sys = ~clk_sys;
  int cyc = 0;
  always @(posedge clk_sys) cyc <= cyc + 1;
  logic [7:0] ram [0:(1<<AW)-1];
  always @(posedge clk_sys) begin
    if (mem_we === 1'b1) ram[mem_addr] <= mem_wdata;
    mem_rdata <= ram[mem_addr];
  end
  typedef struct { logic [AW-1:0] a; logic [7:0] d; int c; } wr_t;
  typedef struct { int c; logic [7:0] d; bit k; } ack_t;
  wr_t  wr_q[$];
  ack_t ack_q[$];
  int   done_q[$];
  int checks = 0, errors = 0, mon_checks = 0, mon_errors = 0;
  always @(negedge clk_sys) begin : mon
    wr_t  ew;
    ack_t ea;
    int   ed;
    if (mem_we === 1'b1) begin
      mon_checks++;
      if (wr_q.size() == 0) begin
        mon_errors++;
        $display("FAIL mem_write: got addr %h data %h at cycle %0d, required no write", mem_addr, mem_wdata, cyc);
      end else begin
        ew = wr_q.pop_front();
        if (mem_addr !== ew.a || mem_wdata !== ew.d || cyc != ew.c) begin
          mon_errors++;
          $display("FAIL mem_write: got addr %h data %h cycle %0d, required addr %h data %h cycle %0d", mem_addr, mem_wdata, cyc, ew.a, ew.d, ew.c);
        end
      end
    end
    if (cpu_ack === 1'b1) begin
      mon_checks++;
      if (ack_q.size() == 0) begin
        mon_errors++;
        $display("FAIL cpu_ack: got ack at cycle %0d, required none", cyc);
      end else begin
        ea = ack_q.pop_front();
        if (cyc != ea.c || (ea.k && cpu_rdata !== ea.d)) begin
          mon_errors++;
          $display("FAIL cpu_ack: got cycle %0d rdata %h, required cycle %0d rdata %h", cyc, cpu_rdata, ea.c, ea.d);
        end
      end
    end
    if (load_done === 1'b1) begin
      mon_checks++;
      if (done_q.size() == 0) begin
        mon_errors++;
        $display("FAIL load_done: got pulse at cycle %0d, required none", cyc);
      end else begin
        ed = done_q.pop_front();
        if (cyc != ed) begin
          mon_errors++;
          $display("FAIL load_done: got cycle %0d, required cycle %0d", cyc, ed);
        end
      end
    end
  end
  task automatic step();
    @(posedge clk_sys);
    #1;
  endtask
  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h, required %0h", n, a, e);
    end
  endtask
  task automatic push_wr(input logic [AW-1:0] a, input logic [7:0] d, input int c);
    wr_t w;
    w.a = a; w.d = d; w.c = c;
    wr_q.push_back(w);
  endtask
  task automatic push_ack(input int c, input logic [7:0] d, input bit k);
    ack_t x;
    x.c = c; x.d = d; x.k = k;
    ack_q.push_back(x);
  endtask
  task automatic cpu_access(input logic we, input logic [AW-1:0] a, input logic [7:0] d, input bit k);
    cpu_req = 1'b1; cpu_we = we; cpu_addr = a; cpu_wdata = d;
    if (we) push_wr(a, d, cyc);
    push_ack(cyc + 1, d, k);
    step();
    step();
    cpu_req = 1'b0; cpu_we = 1'b0;
    step();
  endtask
  task automatic wr_byte(input logic [24:0] a, input logic [7:0] d, input bit exp_wr);
    ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
    if (exp_wr) push_wr(a[AW-1:0], d, cyc + 1);
    step();
    ioctl_wr = 1'b0;
  endtask
  task automatic end_load(input bit with_wr, input logic [24:0] a, input logic [7:0] d);
    if (with_wr) begin
      ioctl_wr = 1'b1; ioctl_addr = a; ioctl_dout = d;
      push_wr(a[AW-1:0], d, cyc + 1);
    end
    ioctl_download = 1'b0;
    done_q.push_back(cyc + H + 1);
    step();
    ioctl_wr = 1'b0;
    repeat (H - 1) step();
    chk("hold_before_release", cpu_reset_hold, 1);
    step();
    chk("hold_released", cpu_reset_hold, 0);
    step();
  endtask
  task automatic reset_vals(input string p);
    chk({p, "_reset_hold"}, cpu_reset_hold, 1);
    chk({p, "_ioctl_wait"}, ioctl_wait, 0);
    chk({p, "_cpu_ack"}, cpu_ack, 0);
    chk({p, "_mem_we"}, mem_we, 0);
    chk({p, "_load_done"}, load_done, 0);
    chk({p, "_overflow"}, load_overflow, 0);
    chk({p, "_cpu_rdata"}, cpu_rdata, 0);
    chk({p, "_mem_addr"}, mem_addr, 0);
    chk({p, "_mem_wdata"}, mem_wdata, 0);
    chk({p, "_checksum"}, load_checksum, 0);
  endtask
  task automatic release_check(input string p);
    repeat (H - 1) step();
    chk({p, "_held_until_release"}, cpu_reset_hold, 1);
    step();
    chk({p, "_released"}, cpu_reset_hold, 0);
  endtask
  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete in time");
    $fatal(1);
  end
  initial begin
    reset_n = 1'b0; ioctl_download = 1'b0; ioctl_index = 8'd0; ioctl_wr = 1'b0;
    ioctl_addr = '0; ioctl_dout = '0; cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_wdata = '0;
    step();
    step();
    reset_vals("por");
    reset_n = 1'b1;
    release_check("por");
    step();
    cpu_access(1'b1, 15'h0100, 8'h5A, 1'b0);
    cpu_access(1'b0, 15'h0100, 8'h5A, 1'b1);
    ioctl_index = 8'd1; ioctl_download = 1'b1;
    chk("t2_hold_rise_cycle", cpu_reset_hold, 0);
    step();
    chk("t2_hold_after_rise", cpu_reset_hold, 1);
    wr_byte(25'h0, 8'h01, 1'b1);
    wr_byte(25'h1, 8'h02, 1'b1);
    wr_byte(25'h2, 8'h03, 1'b1);
    end_load(1'b0, 25'h0, 8'h00);
    chk("t2_checksum", load_checksum, CS ? 32'h06 : 32'h00);
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 15'h0100;
    push_ack(cyc + 1, 8'h5A, 1'b1);
    ioctl_download = 1'b1;
    chk("t3_wait_rise_cycle", ioctl_wait, 0);
    step();
    chk("t3_wait_drain", ioctl_wait, 1);
    chk("t3_hold_drain", cpu_reset_hold, 1);
    wr_byte(25'h10, 8'h77, 1'b1);
    cpu_req = 1'b0;
    chk("t3_wait_load", ioctl_wait, 0);
    step();
    chk("t3_wait_load2", ioctl_wait, 0);
    end_load(1'b1, 25'h11, 8'h88);
    chk("t3_checksum", load_checksum, CS ? 32'hFF : 32'h00);
    ioctl_index = 8'd2; ioctl_download = 1'b1;
    for (int i = 0; i < 4; i++) begin
      ioctl_wr = (i == 1); ioctl_addr = 25'h5; ioctl_dout = 8'h55;
      step();
      chk("t4_no_reset_hold", cpu_reset_hold, 0);
      chk("t4_no_wait", ioctl_wait, 0);
    end
    ioctl_wr = 1'b0; ioctl_download = 1'b0; ioctl_index = 8'd1;
    step();
    chk("t4_checksum_kept", load_checksum, CS ? 32'hFF : 32'h00);
    ioctl_download = 1'b1;
    step();
    wr_byte(25'h8000, 8'h99, 1'b0);
    chk("t5_overflow_set", load_overflow, 1);
    wr_byte(25'h7FFF, 8'h10, 1'b1);
    end_load(1'b0, 25'h0, 8'h00);
    chk("t5_overflow_sticky", load_overflow, 1);
    chk("t5_checksum", load_checksum, CS ? 32'h10 : 32'h00);
    ioctl_download = 1'b1;
    step();
    chk("t6_overflow_cleared", load_overflow, 0);
    chk("t6_checksum_cleared", load_checksum, 0);
    wr_byte(25'h20, 8'h42, 1'b1);
    ioctl_wr = 1'b1; ioctl_addr = 25'h21; ioctl_dout = 8'h43; reset_n = 1'b0;
    step();
    ioctl_wr = 1'b0; ioctl_download = 1'b0;
    reset_vals("midload");
    reset_n = 1'b1;
    release_check("midload");
    step();
    cpu_access(1'b0, 15'h0020, 8'h42, 1'b1);
    cpu_access(1'b0, 15'h0002, 8'h03, 1'b1);
    cpu_access(1'b0, 15'h7FFF, 8'h10, 1'b1);
    cpu_access(1'b0, 15'h0010, 8'h77, 1'b1);
    cpu_access(1'b0, 15'h0011, 8'h88, 1'b1);
    step();
    chk("wr_queue_drained", wr_q.size(), 0);
    chk("ack_queue_drained", ack_q.size(), 0);
    chk("done_queue_drained", done_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks + mon_checks, errors + mon_errors);
    $finish;
  end
endmodule
